serv_mtimer: RTL

- Machine-timer peripheral that generates the timer-interrupt line (mtip) consumed by the core's CSR/interrupt logic.
- Holds a 64-bit free-running mtime counter and a 64-bit mtimecmp register, both accessible over a 32-bit Wishbone slave port.
- Asserts o_mtip while mtime >= mtimecmp.
- Sits on the peripheral bus next to the core; o_mtip connects to the core's i_mtip input.

---
 rtl/serv_mtimer_if.sv | 23 ++
 rtl/serv_mtimer.sv | 100 ++++++++++
 2 files changed

// File: rtl/serv_mtimer_if.sv
// Wishbone slave bus for the machine timer: 32-bit data, 2-bit word index.
// Carries no logic. Valid/strobe from the master, single-cycle ack from the slave.
// Backpressure: the master holds strobe until it sees ack.
interface serv_mtimer_if;
    logic [1:0]  i_wb_adr;
    logic [31:0] i_wb_dat;
    logic [3:0]  i_wb_sel;
    logic        i_wb_we;
    logic        i_wb_cyc;
    logic        i_wb_stb;
    logic [31:0] o_wb_rdt;
    logic        o_wb_ack;

    modport slave (
        input  i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc, i_wb_stb,
        output o_wb_rdt, o_wb_ack
    );

    modport master (
        output i_wb_adr, i_wb_dat, i_wb_sel, i_wb_we, i_wb_cyc, i_wb_stb,
        input  o_wb_rdt, o_wb_ack
    );
endinterface

// File: rtl/serv_mtimer.sv
// Machine timer: 64-bit mtime/mtimecmp behind Wishbone, level interrupt while mtime >= mtimecmp.
// Latency: writes commit at the acceptance edge; ack and read data follow 1 cycle later; mtip is registered.
// Backpressure: one access per two cycles on a held strobe; never stalls beyond the single ack cycle.
module serv_mtimer #(
    parameter int unsigned PRESCALE  = 1,
    parameter logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_cnt_en,
    serv_mtimer_if.slave  wb,
    output logic          o_mtip
);
    localparam logic [15:0] PS_MAX = 16'(PRESCALE - 1);

    logic [15:0] ps_q, ps_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [31:0] snap_q, snap_d;
    logic [31:0] rdt_q, rdt_d;
    logic        ack_q, ack_d;
    logic        mtip_q, mtip_d;
    logic        tick, accept, wr, rd;
    logic [31:0] wmask;

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] dat,
                                          input logic [31:0] mask);
        return (old & ~mask) | (dat & mask);
    endfunction

    assign accept = wb.i_wb_cyc & wb.i_wb_stb & ~ack_q;
    assign wr     = accept & wb.i_wb_we;
    assign rd     = accept & ~wb.i_wb_we;
    assign tick   = i_cnt_en & (ps_q == PS_MAX);
    assign wmask  = {{8{wb.i_wb_sel[3]}}, {8{wb.i_wb_sel[2]}},
                     {8{wb.i_wb_sel[1]}}, {8{wb.i_wb_sel[0]}}};

    always_comb begin
        ps_d       = ps_q;
        mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
        mtimecmp_d = mtimecmp_q;
        snap_d     = snap_q;
        rdt_d      = rdt_q;
        ack_d      = accept;
        mtip_d     = (mtime_q >= mtimecmp_q);

        if (i_cnt_en) begin
            ps_d = tick ? 16'd0 : ps_q + 16'd1;
        end

        // A bus write to either mtime half replaces the whole next value, so a coincident tick is lost.
        if (wr) begin
            case (wb.i_wb_adr)
                2'd0: mtime_d = {mtime_q[63:32], merge(mtime_q[31:0], wb.i_wb_dat, wmask)};
                2'd1: mtime_d = {merge(mtime_q[63:32], wb.i_wb_dat, wmask), mtime_q[31:0]};
                2'd2: mtimecmp_d = {mtimecmp_q[63:32], merge(mtimecmp_q[31:0], wb.i_wb_dat, wmask)};
                2'd3: mtimecmp_d = {merge(mtimecmp_q[63:32], wb.i_wb_dat, wmask), mtimecmp_q[31:0]};
                default: ;
            endcase
        end

        if (rd) begin
            case (wb.i_wb_adr)
                2'd0: begin
                    rdt_d  = mtime_q[31:0];
                    snap_d = mtime_q[63:32];
                end
                2'd1:    rdt_d = snap_q;
                2'd2:    rdt_d = mtimecmp_q[31:0];
                2'd3:    rdt_d = mtimecmp_q[63:32];
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ps_q       <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= CMP_RESET;
            snap_q     <= '0;
            rdt_q      <= '0;
            ack_q      <= 1'b0;
            mtip_q     <= 1'b0;
        end else begin
            ps_q       <= ps_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            snap_q     <= snap_d;
            rdt_q      <= rdt_d;
            ack_q      <= ack_d;
            mtip_q     <= mtip_d;
        end
    end

    assign wb.o_wb_rdt = rdt_q;
    assign wb.o_wb_ack = ack_q;
    assign o_mtip      = mtip_q;
endmodule
